// File: rtl/tx_word_splitter.sv
// Splits a register-file word into LSB-first bytes for the TX FIFO.
// Writes stall on full; txDone pulses once after the last byte of each word.
module tx_word_splitter #(
    parameter int WORD_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    localparam int BPW  = WORD_WIDTH / BYTE_WIDTH,
    localparam int NB_W = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic [NB_W-1:0]       num_bytes,
    input  logic                  full,
    output logic                  wr_en,
    output logic [BYTE_WIDTH-1:0] data_out,
    output logic                  txDone,
    output logic [1:0]            fsm_state
);

    // Handshake: a word transfers on a rising edge with txValid=1 and txReady=1;
    // txReady is a decode of registered state only, so txValid never reaches it.

    localparam int CNT_W = $clog2(BPW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  ready_en;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      count;
    logic                  accept;
    logic [CNT_W-1:0]      count_load;

    assign accept     = txValid && txReady;
    assign count_load = (num_bytes == '0) ? CNT_W'(BPW) : CNT_W'(num_bytes);
    assign data_out   = shift_reg[BYTE_WIDTH-1:0];
    assign fsm_state  = state;

    // Keeps txReady low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        txReady    = 1'b0;
        wr_en      = 1'b0;
        txDone     = 1'b0;
        case (state)
            ST_IDLE: begin
                txReady = ready_en;
                if (txValid && ready_en) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                wr_en = !full;
                if (!full && (count == CNT_W'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                txDone     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            count     <= '0;
        end else if (accept) begin
            shift_reg <= data_in;
            count     <= count_load;
        end else if (wr_en) begin
            shift_reg <= shift_reg >> BYTE_WIDTH;
            count     <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tx_word_splitter.sv
// Directed bench for tx_word_splitter: per-cycle logs of the byte stream are
// checked against hand-computed write/done/ready patterns and byte queues.
module tb_tx_word_splitter;

    logic        clk;
    logic        rst;
    logic        txValid;
    logic        txReady;
    logic [31:0] data_in;
    logic [1:0]  num_bytes;
    logic        full;
    logic        wr_en;
    logic [7:0]  data_out;
    logic        txDone;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    logic       wr_log   [16];
    logic [7:0] dout_log [16];
    logic       done_log [16];
    logic       rdy_log  [16];
    logic [7:0] exp_q[$];

    tx_word_splitter #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .txValid   (txValid),
        .txReady   (txReady),
        .data_in   (data_in),
        .num_bytes (num_bytes),
        .full      (full),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .txDone    (txDone),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Records n cycles (sampled mid-cycle) while driving full from a bitmask.
    task automatic drain(input int n, input logic [15:0] full_mask);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            full = full_mask[i];
            #1;
            wr_log[i]   = wr_en;
            dout_log[i] = data_out;
            done_log[i] = txDone;
            rdy_log[i]  = txReady;
        end
        full = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] nb, input bit hold);
        int w;
        w = 0;
        @(negedge clk);
        #1;
        while (!txReady && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        total++;
        if (txReady !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: txReady=%b required 1", txReady);
        end
        txValid   = 1'b1;
        data_in   = d;
        num_bytes = nb;
        @(posedge clk);
        #1;
        if (!hold) txValid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; txValid = 1'b0; data_in = '0; num_bytes = '0; full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({txReady, wr_en, txDone, data_out} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b wr=%b done=%b dout=%h required all 0",
                     txReady, wr_en, txDone, data_out);
        end
        total++;
        if (fsm_state !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: state=%b required 00", fsm_state);
        end
        rst = 1'b1;
        #1;
        total++;
        if (txReady !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: txReady=%b required 0", txReady);
        end
        @(negedge clk);
        #1;
        total++;
        if (txReady !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge: txReady=%b required 1", txReady);
        end
    endtask

    task automatic test_full_word;
        logic [15:0] wr_m, done_m, rdy_m;
        wr_m = 16'h000F; done_m = 16'h0010; rdy_m = 16'h0020;
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_word(32'hDDCCBBAA, 2'd0, 1'b0);
        drain(6, 16'h0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== {wr_m[i], done_m[i], rdy_m[i]}) begin
                bad++;
                $display("FAIL full_word_ctl[%0d]: wr/done/rdy=%b%b%b required %b%b%b", i,
                         wr_log[i], done_log[i], rdy_log[i], wr_m[i], done_m[i], rdy_m[i]);
            end
            if (wr_log[i] === 1'b1 && exp_q.size() > 0) begin
                total++;
                if (dout_log[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL full_word_byte[%0d]: data_out=%h required %h", i, dout_log[i], exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_word_count: %0d bytes missing required 0", exp_q.size());
        end
    endtask

    task automatic test_partial;
        logic [15:0] wr_m, done_m, rdy_m;
        wr_m = 16'h0003; done_m = 16'h0004; rdy_m = 16'h0008;
        exp_q = '{8'h11, 8'h22};
        send_word(32'h44332211, 2'd2, 1'b0);
        drain(4, 16'h0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== {wr_m[i], done_m[i], rdy_m[i]}) begin
                bad++;
                $display("FAIL partial_ctl[%0d]: wr/done/rdy=%b%b%b required %b%b%b", i,
                         wr_log[i], done_log[i], rdy_log[i], wr_m[i], done_m[i], rdy_m[i]);
            end
            if (wr_log[i] === 1'b1 && exp_q.size() > 0) begin
                total++;
                if (dout_log[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL partial_byte[%0d]: data_out=%h required %h", i, dout_log[i], exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_stall_mid;
        logic [15:0] wr_m, done_m, rdy_m;
        wr_m = 16'h0183; done_m = 16'h0200; rdy_m = 16'h0400;
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_word(32'hDDCCBBAA, 2'd0, 1'b0);
        drain(11, 16'h007C);
        for (int i = 0; i < 11; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== {wr_m[i], done_m[i], rdy_m[i]}) begin
                bad++;
                $display("FAIL stall_mid_ctl[%0d]: wr/done/rdy=%b%b%b required %b%b%b", i,
                         wr_log[i], done_log[i], rdy_log[i], wr_m[i], done_m[i], rdy_m[i]);
            end
            if (wr_log[i] === 1'b1 && exp_q.size() > 0) begin
                total++;
                if (dout_log[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL stall_mid_byte[%0d]: data_out=%h required %h", i, dout_log[i], exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_mid_count: %0d bytes missing required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] wr_m, done_m, rdy_m;
        wr_m = 16'h03CF; done_m = 16'h0410; rdy_m = 16'h0020;
        exp_q = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h88, 8'h77, 8'h66, 8'h55};
        send_word(32'h0A0B0C0D, 2'd0, 1'b1);
        data_in = 32'h55667788;
        drain(11, 16'h0);
        txValid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== {wr_m[i], done_m[i], rdy_m[i]}) begin
                bad++;
                $display("FAIL b2b_ctl[%0d]: wr/done/rdy=%b%b%b required %b%b%b", i,
                         wr_log[i], done_log[i], rdy_log[i], wr_m[i], done_m[i], rdy_m[i]);
            end
            if (wr_log[i] === 1'b1 && exp_q.size() > 0) begin
                total++;
                if (dout_log[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL b2b_byte[%0d]: data_out=%h required %h", i, dout_log[i], exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: %0d bytes missing required 0", exp_q.size());
        end
        drain(2, 16'h0);
        total++;
        if ({wr_log[0], wr_log[1], rdy_log[0], rdy_log[1]} !== 4'b0011) begin
            bad++;
            $display("FAIL b2b_idle: wr=%b%b rdy=%b%b required wr=00 rdy=11",
                     wr_log[0], wr_log[1], rdy_log[0], rdy_log[1]);
        end
    endtask

    task automatic test_reset_mid;
        send_word(32'hDDCCBBAA, 2'd0, 1'b0);
        drain(2, 16'h0);
        total++;
        if ({wr_log[0], dout_log[0], wr_log[1], dout_log[1]} !== {1'b1, 8'hAA, 1'b1, 8'hBB}) begin
            bad++;
            $display("FAIL rst_mid_pre: wr0=%b d0=%h wr1=%b d1=%h required 1 aa 1 bb",
                     wr_log[0], dout_log[0], wr_log[1], dout_log[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({wr_en, txReady, txDone, data_out} !== 11'b0) begin
            bad++;
            $display("FAIL rst_mid_async: wr=%b rdy=%b done=%b dout=%h required all 0",
                     wr_en, txReady, txDone, data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (txReady !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_release: txReady=%b required 0", txReady);
        end
        drain(5, 16'h0);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== 3'b001) begin
                bad++;
                $display("FAIL rst_mid_after[%0d]: wr/done/rdy=%b%b%b required 001", i,
                         wr_log[i], done_log[i], rdy_log[i]);
            end
        end
    endtask

    task automatic test_stall_last;
        logic [15:0] wr_m, done_m, rdy_m;
        wr_m = 16'h0047; done_m = 16'h0080; rdy_m = 16'h0100;
        exp_q = '{8'h5A, 8'hC3, 8'h7E, 8'h81};
        send_word(32'h817EC35A, 2'd0, 1'b0);
        drain(9, 16'h0038);
        for (int i = 0; i < 9; i++) begin
            total++;
            if ({wr_log[i], done_log[i], rdy_log[i]} !== {wr_m[i], done_m[i], rdy_m[i]}) begin
                bad++;
                $display("FAIL stall_last_ctl[%0d]: wr/done/rdy=%b%b%b required %b%b%b", i,
                         wr_log[i], done_log[i], rdy_log[i], wr_m[i], done_m[i], rdy_m[i]);
            end
            if (wr_log[i] === 1'b1 && exp_q.size() > 0) begin
                total++;
                if (dout_log[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL stall_last_byte[%0d]: data_out=%h required %h", i, dout_log[i], exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_last_count: %0d bytes missing required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_stall_mid();
        test_back_to_back();
        test_reset_mid();
        test_stall_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
